// File: rtl/apu_i2s_tx.sv
// I2S transmitter for the APU mix: box-averages the input over each frame and sends it mono on L and R.
// Build option APU_I2S_DC_BLOCK_EN adds a first-order DC blocker on the per-frame sample.
module apu_i2s_tx #(
  parameter int AUDIO_DEPTH    = 16,
  parameter int BCLK_HALF_LOG2 = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AUDIO_DEPTH-1:0] audio,
  input  logic                   audio_en,
  output logic                   i2s_bclk,
  output logic                   i2s_lrclk,
  output logic                   i2s_sdata,
  output logic [AUDIO_DEPTH-1:0] sample_o,
  output logic                   sample_stb
);

  localparam int CW = BCLK_HALF_LOG2 + 7;
  localparam int AW = AUDIO_DEPTH + CW;
  localparam logic [AUDIO_DEPTH-1:0] MID = {1'b1, {(AUDIO_DEPTH-1){1'b0}}};

  logic [CW-1:0]          cnt, cnt_nxt;
  logic [AW-1:0]          acc, acc_sum;
  logic [AUDIO_DEPTH-1:0] term, avg, raw, sample_nxt;
  logic [5:0]             b_nxt, p_nxt;
  logic [31:0]            word;
  logic                   sdata_nxt;
  logic                   frame_end;

  always_comb begin
    cnt_nxt   = cnt + 1'b1;
    frame_end = &cnt;
    term      = audio_en ? audio : MID;
    acc_sum   = acc + {{CW{1'b0}}, term};
    avg       = acc_sum[AW-1:CW];
    raw       = {~avg[AUDIO_DEPTH-1], avg[AUDIO_DEPTH-2:0]};
    b_nxt     = cnt_nxt[CW-1:BCLK_HALF_LOG2+1];
    p_nxt     = b_nxt - 6'd1;
    // Left-justified slot word; bit 31-s is word[~s] for a 5-bit slot index.
    word      = {sample_o, {(32-AUDIO_DEPTH){1'b0}}};
    sdata_nxt = word[~p_nxt[4:0]];
  end

`ifdef APU_I2S_DC_BLOCK_EN
  localparam int DW = AUDIO_DEPTH + 2;
  localparam logic [AUDIO_DEPTH-1:0] SMAX = {1'b0, {(AUDIO_DEPTH-1){1'b1}}};
  localparam logic [AUDIO_DEPTH-1:0] SMIN = {1'b1, {(AUDIO_DEPTH-1){1'b0}}};

  logic        [AUDIO_DEPTH-1:0] x_prev, y_prev;
  logic signed [DW-1:0]          x_e, xp_e, yp_e, y;

  always_comb begin
    x_e  = {{2{raw[AUDIO_DEPTH-1]}}, raw};
    xp_e = {{2{x_prev[AUDIO_DEPTH-1]}}, x_prev};
    yp_e = {{2{y_prev[AUDIO_DEPTH-1]}}, y_prev};
    y    = x_e - xp_e + yp_e - (yp_e >>> 10);
    // In range only when the three top bits agree.
    if ((&y[DW-1:AUDIO_DEPTH-1]) || !(|y[DW-1:AUDIO_DEPTH-1]))
      sample_nxt = y[AUDIO_DEPTH-1:0];
    else
      sample_nxt = y[DW-1] ? SMIN : SMAX;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_prev <= '0;
      y_prev <= '0;
    end else if (frame_end) begin
      x_prev <= raw;
      y_prev <= sample_nxt;
    end
  end
`else
  always_comb sample_nxt = raw;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      acc        <= '0;
      i2s_bclk   <= 1'b0;
      i2s_lrclk  <= 1'b0;
      i2s_sdata  <= 1'b0;
      sample_o   <= '0;
      sample_stb <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      i2s_bclk   <= cnt_nxt[BCLK_HALF_LOG2];
      i2s_lrclk  <= cnt_nxt[CW-1];
      i2s_sdata  <= sdata_nxt;
      sample_stb <= frame_end;
      if (frame_end) begin
        acc      <= '0;
        sample_o <= sample_nxt;
      end else begin
        acc      <= acc_sum;
      end
    end
  end

endmodule
